// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with its own HI/LO pair: shift-add multiply,
// restoring divide, one bit per cycle, with a final sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCancel,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             oDivZero,
  output logic [1:0]       oState
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state, state_nx;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               rsign, remsign, is_div, dz_pend;

  logic               accept, last, signed_op;
  logic [WIDTH-1:0]   a_val, b_val;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = (state == S_IDLE) && iStart && !iCancel;
  assign last      = (cnt == CNTW'(WIDTH - 1));
  assign signed_op = !iOp[0];
  assign a_val     = (signed_op && iA[WIDTH-1]) ? -iA : iA;
  assign b_val     = (signed_op && iB[WIDTH-1]) ? -iB : iB;

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opb});
  assign rem_nx  = div_ge ? WIDTH'(div_sh - {1'b0, opb}) : div_sh[WIDTH-1:0];

  assign prod_fix = rsign ? -acc : acc;
  assign quo_fix  = dz_pend ? {WIDTH{1'b1}} :
                    (rsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = remsign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign oBusy  = (state != S_IDLE);
  assign oState = state;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (iOp)
            3'b000, 3'b001: state_nx = S_MUL;
            3'b010, 3'b011: state_nx = S_DIV;
            default:        state_nx = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (iCancel)   state_nx = S_IDLE;
        else if (last) state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oHI      <= '0;
      oLO      <= '0;
      oDone    <= 1'b0;
      oDivZero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      rsign    <= 1'b0;
      remsign  <= 1'b0;
      is_div   <= 1'b0;
      dz_pend  <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (iOp)
              3'b100: oHI <= iA;
              3'b101: oLO <= iA;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                cnt     <= '0;
                is_div  <= iOp[1];
                opb     <= iOp[1] ? b_val : a_val;
                acc     <= {{WIDTH{1'b0}}, (iOp[1] ? a_val : b_val)};
                rsign   <= signed_op && (iA[WIDTH-1] ^ iB[WIDTH-1]);
                remsign <= signed_op && iA[WIDTH-1];
                dz_pend <= iOp[1] && (iB == '0);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          acc <= {rem_nx, acc[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          // a cancel here leaves HI/LO and the sticky flag untouched
          if (!iCancel) begin
            if (is_div) begin
              oHI <= rem_fix;
              oLO <= quo_fix;
            end else begin
              oHI <= prod_fix[2*WIDTH-1:WIDTH];
              oLO <= prod_fix[WIDTH-1:0];
            end
            oDivZero <= dz_pend;
            oDone    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a plain-arithmetic model predicts HI/LO and
// the divide-by-zero flag; a monitor compares on every oDone pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;
  logic [1:0]   st;

  muldiv_unit #(.WIDTH(W)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iStart(start), .iOp(op), .iA(a), .iB(b),
    .iCancel(cancel), .oBusy(busy), .oDone(done), .oHI(hi), .oLO(lo),
    .oDivZero(dz), .oState(st)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // returns {divzero, hi, lo} after the operation, given the current model state
  function automatic logic [2*W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint          sx, sy, q, r;
    longint unsigned p;
    logic [W-1:0]    rh, rl;
    logic            rdz;
    rh = m_hi; rl = m_lo; rdz = m_dz;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin q = sx * sy; {rh, rl} = q; rdz = 1'b0; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; {rh, rl} = p; rdz = 1'b0; end
      3'd2, 3'd3: begin
        if (y == '0) begin
          rdz = 1'b1; rl = '1; rh = x;
        end else if (o == 3'd2) begin
          q = sx / sy; r = sx % sy;
          rl = q[W-1:0]; rh = r[W-1:0]; rdz = 1'b0;
        end else begin
          rl = x / y; rh = x % y; rdz = 1'b0;
        end
      end
      3'd4: rh = x;
      3'd5: rl = x;
      default: ;
    endcase
    return {rdz, rh, rl};
  endfunction

  // monitor: every oDone must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check("mon_hi", 64'(hi), 64'(e[2*W-1:W]));
        check("mon_lo", 64'(lo), 64'(e[W-1:0]));
        check("mon_divzero", 64'(dz), 64'(e[2*W]));
      end
    end
  end

  // caller is at a negedge; returns at the negedge after the accepting edge
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W:0] e;
    int cyc;
    e = ref_op(o, x, y);
    if (o <= 3'd3) begin
      exp_q.push_back(e);
      start_op(o, x, y);
      wait_idle(cyc);
      check("busy_cycles", 64'(cyc), 64'(W + 1));
      check("done_at_idle", 64'(done), 64'd1);
    end else begin
      start_op(o, x, y);
      check("direct_hi", 64'(hi), 64'(e[2*W-1:W]));
      check("direct_lo", 64'(lo), 64'(e[W-1:0]));
      check("direct_busy", 64'(busy), 64'd0);
    end
    {m_dz, m_hi, m_lo} = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    int           sel;

    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_divzero", 64'(dz), 64'd0);
    check("rst_state", 64'(st), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd3, 32'h0000_1234, 32'd0);
    check("divzero_sticky", 64'(dz), 64'd1);
    run_op(3'd0, 32'd2, 32'd2);
    check("divzero_cleared", 64'(dz), 64'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0005, 32'd0);
    run_op(3'd6, 32'h1357_9BDF, 32'd3);

    // cancel mid-multiply, with a stray start while busy
    run_op(3'd4, 32'hA5A5_A5A5, 32'd0);
    start_op(3'd0, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    op = 3'd4; a = 32'h1111_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_done", 64'(done), 64'd0);
    check("cancel_hi", 64'(hi), 64'(m_hi));
    check("cancel_lo", 64'(lo), 64'(m_lo));
    check("cancel_divzero", 64'(dz), 64'(m_dz));

    // cancel wins over start in IDLE
    op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_lo", 64'(lo), 64'(m_lo));
    check("idle_cancel_busy", 64'(busy), 64'd0);

    // asynchronous reset in the middle of a divide
    run_op(3'd5, 32'h0000_55AA, 32'd0);
    start_op(3'd2, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_divzero", 64'(dz), 64'd0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd2, 32'd2);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = '0;
      if (sel == 1) ry = '1;
      if (sel == 2) rx = 32'h8000_0000;
      if (sel == 3) ry = 32'($urandom_range(1, 15));
      run_op(ro, rx, ry);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
